// File: rtl/gate_sweep_ctrl.sv
// Exhaustive NAND3 sweep controller: steps {a,b,c} through 000..111, samples the synchronized gate output.
// Optional macro GATE_SWEEP_MEASURE_DELAY_EN adds per-vector response-delay measurement on max_delay.
module gate_sweep_ctrl #(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned CW     = $clog2(SETTLE + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          w,
   output logic          a,
   output logic          b,
   output logic          c,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [3:0]    err_count,
   output logic [2:0]    fail_vec,
   output logic          fail_valid,
   output logic [CW-1:0] max_delay
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_SAMPLE = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam int unsigned VW = 3;
   localparam int unsigned EW = 4;

   state_t        r_state, w_state_nxt;
   logic          r_sync1, r_sync2;
   logic [VW-1:0] r_vec, w_vec_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          r_pass, w_pass_nxt;
   logic [EW-1:0] r_err, w_err_nxt;
   logic [VW-1:0] r_fail_vec, w_fail_vec_nxt;
   logic          r_fail_valid, w_fail_valid_nxt;
   logic          w_exp;
   logic          w_mis;

   assign w_exp = ~(&r_vec);
   assign w_mis = (r_sync2 != w_exp);

   // Two-flop synchronizer for the asynchronous gate output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= w;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_vec        <= '0;
         r_cnt        <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err        <= '0;
         r_fail_vec   <= '0;
         r_fail_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_vec        <= w_vec_nxt;
         r_cnt        <= w_cnt_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pass       <= w_pass_nxt;
         r_err        <= w_err_nxt;
         r_fail_vec   <= w_fail_vec_nxt;
         r_fail_valid <= w_fail_valid_nxt;
      end
   end

   // Next-state and next-output logic; results only change on an accepted start or a sample
   always_comb begin
      w_state_nxt      = r_state;
      w_vec_nxt        = r_vec;
      w_cnt_nxt        = r_cnt;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_pass_nxt       = r_pass;
      w_err_nxt        = r_err;
      w_fail_vec_nxt   = r_fail_vec;
      w_fail_valid_nxt = r_fail_valid;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_err_nxt        = '0;
               w_fail_vec_nxt   = '0;
               w_fail_valid_nxt = 1'b0;
               w_pass_nxt       = 1'b0;
               w_vec_nxt        = '0;
               w_cnt_nxt        = '0;
               w_busy_nxt       = 1'b1;
               w_state_nxt      = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (r_cnt == CW'(SETTLE - 1)) begin
               w_state_nxt = S_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         S_SAMPLE: begin
            if (w_mis) begin
               w_err_nxt = r_err + EW'(1);
               if (!r_fail_valid) begin
                  w_fail_vec_nxt   = r_vec;
                  w_fail_valid_nxt = 1'b1;
               end
            end
            if (r_vec == VW'(7)) begin
               w_state_nxt = S_DONE;
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_pass_nxt  = (w_err_nxt == '0);
            end else begin
               w_vec_nxt   = r_vec + VW'(1);
               w_cnt_nxt   = '0;
               w_state_nxt = S_SETTLE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef GATE_SWEEP_MEASURE_DELAY_EN
   logic          r_matched, w_matched_nxt;
   logic [CW-1:0] r_max_delay, w_max_delay_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_matched   <= 1'b0;
         r_max_delay <= '0;
      end else begin
         r_matched   <= w_matched_nxt;
         r_max_delay <= w_max_delay_nxt;
      end
   end

   // First settle cycle with a correct response sets the vector's delay; no match counts as SETTLE
   always_comb begin
      w_matched_nxt   = r_matched;
      w_max_delay_nxt = r_max_delay;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_matched_nxt   = 1'b0;
               w_max_delay_nxt = '0;
            end
         end
         S_SETTLE: begin
            if (!r_matched && !w_mis) begin
               w_matched_nxt = 1'b1;
               if (r_cnt > r_max_delay) begin
                  w_max_delay_nxt = r_cnt;
               end
            end
         end
         S_SAMPLE: begin
            if (!r_matched && (CW'(SETTLE) > r_max_delay)) begin
               w_max_delay_nxt = CW'(SETTLE);
            end
            w_matched_nxt = 1'b0;
         end
         default: begin
            w_matched_nxt = r_matched;
         end
      endcase
   end

   assign max_delay = r_max_delay;
`else
   assign max_delay = '0;
`endif

   assign {a, b, c}  = r_vec;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pass       = r_pass;
   assign err_count  = r_err;
   assign fail_vec   = r_fail_vec;
   assign fail_valid = r_fail_valid;

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Exhaustive stimulus controller for the 3-input NAND gate under test. Drives the gate's `a`, `b`, `c` inputs through all eight input combinations, waits a programmable settle window, samples the gate output through a synchronizer, and checks it against the expected NAND function. Reports an error count, the first failing vector, and a pass flag. Sits between a start request from the lab harness and one NAND3 instance.

## Interface
- `SETTLE`, default 4, cycles each vector is held before sampling; legal range 3..255.
- `CW`, default `$clog2(SETTLE+1)`, width of the settle and delay counters.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: sweep request; sampled only in IDLE.
- `w` input 1: gate output; asynchronous to `clk`.
- `a`, `b`, `c` output 1 each: registered gate inputs; `{a,b,c}` equals the current vector, with `a` as the MSB.
- `busy` output 1: sweep in progress.
- `done` output 1: one-cycle pulse when the sweep ends.
- `pass` output 1: the last sweep had zero mismatches.
- `err_count` output 4: mismatches in the last sweep, range 0..8.
- `fail_vec` output 3: first mismatching vector.
- `fail_valid` output 1: `fail_vec` is meaningful.
- `max_delay` output CW: worst per-vector response delay (see Configuration).

## Operation
- **Reset values:** every output is 0, including `{a,b,c}=000`. FSM is in IDLE, vector counter is 0, synchronizer flops are 0.
- **Synchronizer:** `w` passes through a 2-flop synchronizer to give `w_s`. All compares use `w_s`.
- **Expected value:** `exp = ~(a & b & c)`.
- **IDLE:**
  - `start=1` clears `err_count`, `fail_valid`, `fail_vec`, `pass` and `max_delay`.
  - Sets vector to 000 and `busy=1`, then moves to SETTLE with the settle counter at 0.
- **SETTLE:**
  - Settle counter increments every cycle.
  - When it reaches SETTLE-1, the FSM moves to SAMPLE.
- **SAMPLE:**
  - If `w_s != exp`: `err_count` increments. If `fail_valid=0`, then `fail_vec` takes the current vector and `fail_valid` is set.
  - If vector is 111: move to DONE.
  - Otherwise: vector increments, settle counter clears, and the FSM returns to SETTLE.
- **DONE:**
  - `done=1` and `busy=0`.
  - `pass` is set to `(err_count==0)`, counting the final sample.
  - Next state is IDLE.
  - `{a,b,c}` holds 111 until the next start.
- **Result holding:** results hold until the next accepted `start`.
- **`start` while busy:** ignored, no restart.
- **`start` in DONE:** ignored; it is accepted from IDLE on the following cycle if still high.
- **Reset mid-sweep:** immediate abort to reset values. No `done` pulse.
- **No saturation needed:** `err_count` cannot exceed 8.

## Timing
- Vector sequence: 000, 001, …, 111, one step per SETTLE+1 cycles.
- Vector 000 appears on `{a,b,c}` in the cycle after the edge that accepted `start`.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 in SAMPLE.
- `done` is high exactly 8·(SETTLE+1)+1 cycles after the accepting edge; 41 for SETTLE=4.
- `busy` is high for 8·(SETTLE+1) cycles.
- `w` must be stable at `w_s` by the last SETTLE cycle. The gate's delay plus 2 sync cycles must be ≤ SETTLE-1, which is why SETTLE ≥ 3.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro `GATE_SWEEP_MEASURE_DELAY_EN`, when defined:**
  - Per vector, the delay is the settle-counter value in the first SETTLE cycle where `w_s == exp`. If there is no match before SAMPLE, the delay is SETTLE.
  - `max_delay` tracks the maximum delay across the sweep and is valid when `done` pulses.
- **When not defined:**
  - `max_delay` is tied to 0 and no delay logic is synthesized.
  - Check behaviour is identical in both cases.

## Test plan
- **Ideal combinational NAND3 model, SETTLE=4:** `start` pulse → vectors 000..111 each held 5 cycles; `done` at cycle 41; `err_count=0`, `pass=1`, `fail_valid=0`.
- **Stuck-at-1 model (`w=1`):** full sweep → `err_count=1`, `fail_vec=111`, `fail_valid=1`, `pass=0`.
- **Stuck-at-0 model (`w=0`):** full sweep → `err_count=7`, `fail_vec=000`, `pass=0`.
- **Busy behaviour and mid-sweep reset:**
  - `start` re-asserted during vector 011 → no restart, sequence unaffected.
  - `rst_n` low during vector 101 → all outputs 0 immediately, no `done`.
  - A new `start` after reset then completes normally.
- **With `GATE_SWEEP_MEASURE_DELAY_EN`:**
  - Ideal combinational model → `max_delay=2`.
  - Model with 1 extra cycle of output delay → `max_delay=3`.
  - Without the macro → `max_delay=0`.
